// File: rtl/lcl_wr_burst_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : lcl_wr_burst_gen_if
//  Description : Local-bus burst interface between the burst generator
//                (master) and the AXI write master (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface lcl_wr_burst_gen_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  lcl_istart;
    logic [ADDR_WIDTH-1:0] lcl_iaddr;
    logic [7:0]            lcl_inum;
    logic                  lcl_ibusy;
    logic                  lcl_irdy;
    logic                  lcl_den;
    logic [DATA_WIDTH-1:0] lcl_din;
    logic                  lcl_idone;

    modport master (
        output lcl_istart, lcl_iaddr, lcl_inum, lcl_den, lcl_din, lcl_idone,
        input  lcl_ibusy, lcl_irdy
    );

    modport slave (
        input  lcl_istart, lcl_iaddr, lcl_inum, lcl_den, lcl_din, lcl_idone,
        output lcl_ibusy, lcl_irdy
    );
endinterface
`default_nettype wire

// File: rtl/lcl_wr_burst_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lcl_wr_burst_gen
//  Description : Splits a write job into local-bus bursts of at most
//                MAX_BEATS beats that never cross a 4 KB page, and forwards
//                the input stream to the write master one burst at a time.
//  Revision    : 1.0  initial release
// ============================================================================
module lcl_wr_burst_gen #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BEATS  = 64
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  clear,
    input  wire logic                  job_start,
    input  wire logic [ADDR_WIDTH-1:0] job_addr,
    input  wire logic [31:0]           job_beats,
    output logic                       job_busy,
    output logic                       job_done,
    input  wire logic                  s_valid,
    input  wire logic [DATA_WIDTH-1:0] s_data,
    output logic                       s_ready,
    lcl_wr_burst_gen_if.master         lcl,
    output logic [15:0]                burst_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CALC  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WAITB = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [7:0]            C_MAX_BEATS = 8'(MAX_BEATS);
    localparam logic [ADDR_WIDTH-1:0] C_BEAT_MASK = ~ADDR_WIDTH'(7);

    logic [2:0]            state_q,     state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q,  cur_addr_d;
    logic [31:0]           rem_q,       rem_d;
    logic [7:0]            blen_q,      blen_d;
    logic [7:0]            beat_left_q, beat_left_d;
    logic [15:0]           burst_cnt_q, burst_cnt_d;
    logic                  job_busy_q,  job_busy_d;
    logic                  job_done_q,  job_done_d;
    logic                  istart_q,    istart_d;
    logic [ADDR_WIDTH-1:0] iaddr_q,     iaddr_d;
    logic [7:0]            inum_q,      inum_d;
    logic                  den_q,       den_d;
    logic [DATA_WIDTH-1:0] din_q,       din_d;
    logic                  idone_q,     idone_d;

    logic [9:0] w_page_left;
    logic [7:0] w_page_sat;
    logic [7:0] w_rem_sat;
    logic [7:0] w_min_a;
    logic [7:0] w_blen;
    logic       w_ready;
    logic       w_accept;
    logic       w_last;

    // Beats left in the 4 KB page, then burst length = min(rem, MAX, page).
    // All candidates saturate at 255 since MAX_BEATS never exceeds that.
    assign w_page_left = 10'd512 - {1'b0, cur_addr_q[11:3]};
    assign w_page_sat  = (w_page_left > 10'd255) ? 8'hFF : w_page_left[7:0];
    assign w_rem_sat   = (rem_q > 32'd255) ? 8'hFF : rem_q[7:0];
    assign w_min_a     = (w_rem_sat < C_MAX_BEATS) ? w_rem_sat : C_MAX_BEATS;
    assign w_blen      = (w_page_sat < w_min_a) ? w_page_sat : w_min_a;

    assign w_ready  = (state_q == S_DATA) && lcl.lcl_irdy && (beat_left_q != 8'd0);
    assign w_accept = s_valid && w_ready;
    assign w_last   = w_accept && (beat_left_q == 8'd1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear always returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (job_start) state_d = (job_beats == 32'd0) ? S_DONE : S_CALC;
            S_CALC:  state_d = S_ISSUE;
            S_ISSUE: if (!lcl.lcl_ibusy) state_d = S_DATA;
            S_DATA:  if (w_last) state_d = S_WAITB;
            S_WAITB: if (!lcl.lcl_ibusy) state_d = (rem_q != 32'd0) ? S_CALC : S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (clear) begin
            state_d = S_IDLE;
        end
    end

    // Output and datapath next values for every registered output
    always_comb begin
        cur_addr_d  = cur_addr_q;
        rem_d       = rem_q;
        blen_d      = blen_q;
        beat_left_d = beat_left_q;
        burst_cnt_d = burst_cnt_q;
        job_busy_d  = job_busy_q;
        job_done_d  = 1'b0;
        istart_d    = 1'b0;
        iaddr_d     = iaddr_q;
        inum_d      = inum_q;
        den_d       = 1'b0;
        din_d       = din_q;
        idone_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (job_start) begin
                    cur_addr_d  = job_addr & C_BEAT_MASK;
                    rem_d       = job_beats;
                    burst_cnt_d = 16'd0;
                    job_busy_d  = 1'b1;
                end
            end
            S_CALC: begin
                blen_d  = w_blen;
                iaddr_d = cur_addr_q;
                inum_d  = w_blen;
            end
            S_ISSUE: begin
                if (!lcl.lcl_ibusy) begin
                    istart_d    = 1'b1;
                    burst_cnt_d = burst_cnt_q + 16'd1;
                    beat_left_d = blen_q;
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    den_d       = 1'b1;
                    din_d       = s_data;
                    beat_left_d = beat_left_q - 8'd1;
                end
                if (w_last) begin
                    idone_d    = 1'b1;
                    cur_addr_d = cur_addr_q + ADDR_WIDTH'({blen_q, 3'b000});
                    rem_d      = rem_q - {24'd0, blen_q};
                end
            end
            S_DONE: begin
                job_done_d = 1'b1;
                job_busy_d = 1'b0;
            end
            default: ;
        endcase
        // Abort: drop the job silently and keep the burst count for inspection
        if (clear) begin
            burst_cnt_d = burst_cnt_q;
            job_busy_d  = 1'b0;
            job_done_d  = 1'b0;
            istart_d    = 1'b0;
            den_d       = 1'b0;
            idone_d     = 1'b0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr_q  <= '0;
            rem_q       <= '0;
            blen_q      <= '0;
            beat_left_q <= '0;
            burst_cnt_q <= '0;
            job_busy_q  <= 1'b0;
            job_done_q  <= 1'b0;
            istart_q    <= 1'b0;
            iaddr_q     <= '0;
            inum_q      <= '0;
            den_q       <= 1'b0;
            din_q       <= '0;
            idone_q     <= 1'b0;
        end else begin
            cur_addr_q  <= cur_addr_d;
            rem_q       <= rem_d;
            blen_q      <= blen_d;
            beat_left_q <= beat_left_d;
            burst_cnt_q <= burst_cnt_d;
            job_busy_q  <= job_busy_d;
            job_done_q  <= job_done_d;
            istart_q    <= istart_d;
            iaddr_q     <= iaddr_d;
            inum_q      <= inum_d;
            den_q       <= den_d;
            din_q       <= din_d;
            idone_q     <= idone_d;
        end
    end

    assign s_ready        = w_ready;
    assign job_busy       = job_busy_q;
    assign job_done       = job_done_q;
    assign burst_cnt      = burst_cnt_q;
    assign lcl.lcl_istart = istart_q;
    assign lcl.lcl_iaddr  = iaddr_q;
    assign lcl.lcl_inum   = inum_q;
    assign lcl.lcl_den    = den_q;
    assign lcl.lcl_din    = din_q;
    assign lcl.lcl_idone  = idone_q;

endmodule
`default_nettype wire

// File: tb/tb_lcl_wr_burst_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcl_wr_burst_gen
//  Description : Directed self-checking bench for lcl_wr_burst_gen with a
//                small write-master model and an incrementing data source.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lcl_wr_burst_gen;
    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int MAXB = 64;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           clear     = 1'b0;
    logic           job_start = 1'b0;
    logic [AW-1:0]  job_addr  = '0;
    logic [31:0]    job_beats = '0;
    logic           job_busy;
    logic           job_done;
    logic           s_valid   = 1'b0;
    logic [DW-1:0]  s_data;
    logic           s_ready;
    logic [15:0]    burst_cnt;

    lcl_wr_burst_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) lcl_bus ();

    lcl_wr_burst_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BEATS(MAXB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .job_start (job_start),
        .job_addr  (job_addr),
        .job_beats (job_beats),
        .job_busy  (job_busy),
        .job_done  (job_done),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .lcl       (lcl_bus),
        .burst_cnt (burst_cnt)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] seq     = 32'd0;
    logic [31:0] exp_seq = 32'd0;
    int          nb, den_cnt, idone_cnt, idone_beat, done_cnt, done_cyc, fall_cyc;
    int          busy_viol, ready_viol, order_err, tail, start_cyc, busy_at_done;
    int          irdy_mode = 0;
    int          valid_mode = 0;
    logic        pre_acc;
    logic [63:0] b_addr [8];
    int          b_num  [8];

    assign s_data = {32'hFACE_0000, seq};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One clock: sample the handshake mid-cycle, observe registered outputs
    // just after the edge, then advance the write-master model and stimulus.
    task automatic tick();
        @(negedge clk);
        pre_acc = s_valid && s_ready;
        if (s_ready && (!lcl_bus.lcl_irdy || !job_busy)) ready_viol++;
        @(posedge clk);
        #1;
        cyc++;
        if (pre_acc) seq++;
        if (lcl_bus.lcl_istart) begin
            if (lcl_bus.lcl_ibusy) busy_viol++;
            if (nb < 8) begin
                b_addr[nb] = lcl_bus.lcl_iaddr;
                b_num[nb]  = int'(lcl_bus.lcl_inum);
            end
            nb++;
        end
        if (lcl_bus.lcl_den) begin
            den_cnt++;
            if (lcl_bus.lcl_din !== {32'hFACE_0000, exp_seq}) order_err++;
            exp_seq++;
            if (lcl_bus.lcl_idone) begin
                idone_cnt++;
                idone_beat = den_cnt;
            end
        end else if (lcl_bus.lcl_idone) begin
            idone_cnt++;
        end
        if (job_done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = int'(job_busy);
        end
        if (lcl_bus.lcl_istart) lcl_bus.lcl_ibusy = 1'b1;
        if (lcl_bus.lcl_idone) begin
            tail = 2;
        end else if (tail > 0) begin
            tail--;
            if (tail == 0) begin
                lcl_bus.lcl_ibusy = 1'b0;
                fall_cyc = cyc;
            end
        end
        lcl_bus.lcl_irdy = (irdy_mode == 0) ? 1'b1 : (((cyc / 3) % 2) == 0);
        s_valid = (valid_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    endtask

    task automatic start_job(input logic [63:0] a, input int beats, input int im, input int vm);
        nb = 0; den_cnt = 0; idone_cnt = 0; idone_beat = 0; done_cnt = 0;
        done_cyc = 0; fall_cyc = 0; busy_viol = 0; ready_viol = 0; order_err = 0;
        busy_at_done = 1;
        irdy_mode  = im;
        valid_mode = vm;
        exp_seq    = seq;
        job_addr   = a;
        job_beats  = 32'(beats);
        job_start  = 1'b1;
        start_cyc  = cyc;
        tick();
        job_start  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        check_val({tag, "_done_seen"}, 64'(done_cnt), 64'd1);
        repeat (3) tick();
        check_val({tag, "_done_once"}, 64'(done_cnt), 64'd1);
        check_val({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        lcl_bus.lcl_ibusy = 1'b0;
        lcl_bus.lcl_irdy  = 1'b1;
        tail = 0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_job_busy", 64'(job_busy), 64'd0);
        check_val("rst_job_done", 64'(job_done), 64'd0);
        check_val("rst_s_ready",  64'(s_ready), 64'd0);
        check_val("rst_istart",   64'(lcl_bus.lcl_istart), 64'd0);
        check_val("rst_iaddr",    lcl_bus.lcl_iaddr, 64'd0);
        check_val("rst_inum",     64'(lcl_bus.lcl_inum), 64'd0);
        check_val("rst_den",      64'(lcl_bus.lcl_den), 64'd0);
        check_val("rst_idone",    64'(lcl_bus.lcl_idone), 64'd0);
        check_val("rst_burst_cnt", 64'(burst_cnt), 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single page-aligned burst of MAX_BEATS
        start_job(64'h1000, 64, 0, 0);
        check_val("t1_busy", 64'(job_busy), 64'd1);
        wait_done("t1", 2000);
        check_val("t1_nb",     64'(nb), 64'd1);
        check_val("t1_addr0",  b_addr[0], 64'h1000);
        check_val("t1_num0",   64'(b_num[0]), 64'd64);
        check_val("t1_den",    64'(den_cnt), 64'd64);
        check_val("t1_idone_n", 64'(idone_cnt), 64'd1);
        check_val("t1_idone_beat", 64'(idone_beat), 64'd64);
        check_val("t1_order",  64'(order_err), 64'd0);
        check_val("t1_bcnt",   64'(burst_cnt), 64'd1);
        // busy low sampled in WAITB -> DONE -> pulse: two cycles
        check_val("t1_done_lat", 64'(done_cyc - fall_cyc), 64'd2);

        // 4 KB boundary split
        start_job(64'h1FC0, 20, 0, 0);
        wait_done("t2", 2000);
        check_val("t2_nb",    64'(nb), 64'd2);
        check_val("t2_addr0", b_addr[0], 64'h1FC0);
        check_val("t2_num0",  64'(b_num[0]), 64'd8);
        check_val("t2_addr1", b_addr[1], 64'h2000);
        check_val("t2_num1",  64'(b_num[1]), 64'd12);
        check_val("t2_den",   64'(den_cnt), 64'd20);
        check_val("t2_bcnt",  64'(burst_cnt), 64'd2);

        // MAX_BEATS split into three bursts
        start_job(64'h0, 150, 0, 0);
        wait_done("t3", 3000);
        check_val("t3_nb",    64'(nb), 64'd3);
        check_val("t3_addr0", b_addr[0], 64'h0);
        check_val("t3_num0",  64'(b_num[0]), 64'd64);
        check_val("t3_addr1", b_addr[1], 64'h200);
        check_val("t3_num1",  64'(b_num[1]), 64'd64);
        check_val("t3_addr2", b_addr[2], 64'h400);
        check_val("t3_num2",  64'(b_num[2]), 64'd22);
        check_val("t3_den",   64'(den_cnt), 64'd150);
        check_val("t3_idone_n", 64'(idone_cnt), 64'd3);
        check_val("t3_busy_viol", 64'(busy_viol), 64'd0);
        check_val("t3_order", 64'(order_err), 64'd0);
        check_val("t3_bcnt",  64'(burst_cnt), 64'd3);

        // Throttled sink and bursty source
        start_job(64'h3000, 32, 1, 1);
        wait_done("t4", 3000);
        check_val("t4_den",        64'(den_cnt), 64'd32);
        check_val("t4_order",      64'(order_err), 64'd0);
        check_val("t4_ready_viol", 64'(ready_viol), 64'd0);
        check_val("t4_idone_n",    64'(idone_cnt), 64'd1);
        check_val("t4_idone_beat", 64'(idone_beat), 64'd32);
        irdy_mode = 0;
        valid_mode = 0;

        // Empty job
        start_job(64'h8000, 0, 0, 0);
        wait_done("t5", 50);
        check_val("t5_done_lat", 64'(done_cyc - start_cyc), 64'd2);
        check_val("t5_nb",       64'(nb), 64'd0);
        check_val("t5_bcnt",     64'(burst_cnt), 64'd0);

        // Abort mid-burst, then a fresh job with unaligned address
        start_job(64'h4000, 64, 0, 0);
        begin
            int n = 0;
            while (den_cnt < 10 && n < 500) begin
                tick();
                n++;
            end
        end
        check_val("t6_reached10", 64'(den_cnt), 64'd10);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        lcl_bus.lcl_ibusy = 1'b0;
        tail = 0;
        check_val("t6_s_ready", 64'(s_ready), 64'd0);
        check_val("t6_busy",    64'(job_busy), 64'd0);
        check_val("t6_den",     64'(lcl_bus.lcl_den), 64'd0);
        check_val("t6_idone",   64'(lcl_bus.lcl_idone), 64'd0);
        check_val("t6_bcnt",    64'(burst_cnt), 64'd1);
        repeat (6) tick();
        check_val("t6_no_done", 64'(done_cnt), 64'd0);
        check_val("t6_no_den",  64'(den_cnt), 64'd10);
        start_job(64'h500D, 16, 0, 0);
        wait_done("t6b", 2000);
        check_val("t6b_nb",    64'(nb), 64'd1);
        check_val("t6b_addr0", b_addr[0], 64'h5008);
        check_val("t6b_num0",  64'(b_num[0]), 64'd16);
        check_val("t6b_den",   64'(den_cnt), 64'd16);
        check_val("t6b_order", 64'(order_err), 64'd0);
        check_val("t6b_bcnt",  64'(burst_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
